// File: rtl/dispatch_ctrl.sv
// Dual-issue dispatch controller: pops 0..2 contiguous entries from the decode queue head.
// Latency: issue_valid/dequeue_en are combinational from the queue head; scoreboard, FSM and counters update on clk.
// Backpressure: ex_stall suppresses issue and freezes the load-use countdown; flush kills the cycle's issue.
//
// Ports:
//   clk, rst (sync, active-low)  flush, ex_stall, pipe_empty  control inputs
//   q_*                          per-slot decode info, slot0 is the older entry
//   issue_valid, dequeue_en      identical contiguous issue/pop masks
//   dual_cnt, stall_cnt          free-running performance counters
module dispatch_ctrl #(
  parameter int unsigned LU_DELAY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [1:0]      q_valid,
  input  logic [1:0]      q_reg1_ren,
  input  logic [1:0]      q_reg2_ren,
  input  logic [1:0][4:0] q_reg1_addr,
  input  logic [1:0][4:0] q_reg2_addr,
  input  logic [1:0]      q_wen,
  input  logic [1:0][4:0] q_waddr,
  input  logic [1:0]      q_is_load,
  input  logic [1:0]      q_is_mem,
  input  logic [1:0]      q_is_privilege,
  input  logic [1:0]      q_is_exception,
  input  logic            ex_stall,
  input  logic            pipe_empty,
  output logic [1:0]      dequeue_en,
  output logic [1:0]      issue_valid,
  output logic [31:0]     dual_cnt,
  output logic [31:0]     stall_cnt
);

  localparam int CW = (LU_DELAY < 1) ? 1 : $clog2(LU_DELAY + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [4:0]      r_lu_addr;
  logic [CW-1:0]   r_lu_cnt;
  logic [31:0]     r_dual_cnt;
  logic [31:0]     r_stall_cnt;

  logic            w_lu_busy;
  logic [1:0]      w_haz;
  logic            w_raw;
  logic            w_head_ok;
  logic            w_pair_ok;
  logic [1:0]      w_issue;
  logic [1:0]      w_ld_hit;
  logic            w_unused;

  // Only the older slot's exception flag matters: a younger excepting
  // instruction is simply issued and handled downstream.
  assign w_unused  = q_is_exception[1];

  assign w_lu_busy = (r_lu_cnt != '0);

  // Load-use hazard per slot: an enabled, non-r0 source matching the pending load.
  always_comb begin
    w_haz = '0;
    for (int k = 0; k < 2; k++) begin
      w_haz[k] = w_lu_busy &
                 ((q_reg1_ren[k] && (q_reg1_addr[k] != 5'd0) && (q_reg1_addr[k] == r_lu_addr)) ||
                  (q_reg2_ren[k] && (q_reg2_addr[k] != 5'd0) && (q_reg2_addr[k] == r_lu_addr)));
    end
  end

  // Slot1 reading what slot0 writes in the same cycle cannot be paired.
  assign w_raw = q_wen[0] && (q_waddr[0] != 5'd0) &&
                 ((q_reg1_ren[1] && (q_reg1_addr[1] == q_waddr[0])) ||
                  (q_reg2_ren[1] && (q_reg2_addr[1] == q_waddr[0])));

  assign w_head_ok = q_valid[0] && !ex_stall && !w_haz[0];

  assign w_pair_ok = q_valid[1] && !w_haz[1] && !q_is_privilege[1] &&
                     !q_is_exception[0] && !(q_is_mem[0] && q_is_mem[1]) && !w_raw;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. A privileged head must see an empty pipe to issue;
  // afterwards HOLD keeps younger work back until it has left the pipe.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (q_valid[0] && q_is_privilege[0]) begin
            w_next = (w_head_ok && pipe_empty) ? S_HOLD : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_head_ok && pipe_empty) begin
            w_next = S_HOLD;
          end
        end
        S_HOLD: begin
          if (pipe_empty) begin
            w_next = S_RUN;
          end
        end
        default: w_next = S_RUN;
      endcase
    end
  end

  // Output logic. Slot1 can only be set when slot0 is, so the mask is contiguous.
  always_comb begin
    w_issue = 2'b00;
    if (rst && !flush) begin
      case (r_state)
        S_RUN: begin
          if (w_head_ok) begin
            if (q_is_privilege[0]) begin
              w_issue[0] = pipe_empty;
            end else begin
              w_issue[0] = 1'b1;
              w_issue[1] = w_pair_ok;
            end
          end
        end
        S_DRAIN: begin
          if (w_head_ok && pipe_empty) begin
            w_issue = 2'b01;
          end
        end
        default: w_issue = 2'b00;
      endcase
    end
  end

  assign issue_valid = w_issue;
  assign dequeue_en  = w_issue;

  always_comb begin
    w_ld_hit = '0;
    for (int k = 0; k < 2; k++) begin
      w_ld_hit[k] = w_issue[k] && q_is_load[k] && q_wen[k] && (q_waddr[k] != 5'd0);
    end
  end

  // Single-entry load scoreboard; the newest load replaces any older one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lu_addr <= 5'd0;
      r_lu_cnt  <= '0;
    end else if (flush) begin
      r_lu_cnt  <= '0;
    end else if (w_ld_hit[1]) begin
      r_lu_addr <= q_waddr[1];
      r_lu_cnt  <= CW'(LU_DELAY);
    end else if (w_ld_hit[0]) begin
      r_lu_addr <= q_waddr[0];
      r_lu_cnt  <= CW'(LU_DELAY);
    end else if (w_lu_busy && !ex_stall) begin
      r_lu_cnt  <= r_lu_cnt - CW'(1);
    end
  end

  // Performance counters: wrap naturally, untouched by flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dual_cnt  <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_issue == 2'b11) begin
        r_dual_cnt <= r_dual_cnt + 32'd1;
      end
      if (q_valid[0] && !w_issue[0]) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign dual_cnt  = r_dual_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule
